// File: rtl/dmem_stage.sv
// RV32I memory-access stage: one request/acknowledge data-bus transaction per load/store,
// load lane selection with sign/zero extension, and one-cycle pass-through for everything else.
`timescale 1ns/1ps
module dmem_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        pen_p_1,
  input  logic [31:0] alu_p_1,
  input  logic [31:0] rd2_p_1,
  input  logic [4:0]  rad_p_1,
  input  logic        rad_zero_p_1,
  input  logic [31:0] instr_p_1,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        pen,
  output logic [4:0]  rad,
  output logic        rad_zero,
  output logic [31:0] rdd,
  output logic        wr_en,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t      r_state;
  logic [9:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_ld_f3;
  logic [1:0]  r_ld_lo;
  logic        r_pen;
  logic [4:0]  r_rad;
  logic        r_rad_zero;
  logic [31:0] r_rdd;
  logic        r_wr_en;
  logic        r_misalign;
  logic        r_bus_err;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_memop;
  logic        w_bad_f3;
  logic        w_misal;
  logic        w_fault;
  logic        w_memop_valid;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;
  logic        w_unused;

  assign w_opcode   = instr_p_1[6:0];
  assign w_f3       = instr_p_1[14:12];
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_memop    = pen_p_1 & (w_is_load | w_is_store);
  assign w_unused   = &{1'b0, instr_p_1[31:15], instr_p_1[11:7]};

  // Size comes from funct3[1:0]: 00 byte, 01 half, 10 word; illegal codes fault regardless.
  assign w_bad_f3 = w_is_load ? ((w_f3 == 3'd3) | (w_f3 == 3'd6) | (w_f3 == 3'd7))
                              : (w_f3[2] | (w_f3 == 3'd3));
  assign w_misal  = ((w_f3[1:0] == 2'b01) & alu_p_1[0]) |
                    ((w_f3[1:0] == 2'b10) & (alu_p_1[1:0] != 2'b00));
  assign w_fault       = w_memop & (w_bad_f3 | w_misal);
  assign w_memop_valid = w_memop & ~w_fault;

  assign w_timeout = (r_state == S_BUS) && (r_cnt == 10'(ACK_TIMEOUT - 1));
  assign stall     = w_memop_valid & ~((r_state == S_BUS) & (dmem_ack | w_timeout));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rd2_p_1;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_p_1[1:0];
        w_wdata = {4{rd2_p_1[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << alu_p_1[1:0];
        w_wdata = {2{rd2_p_1[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = rd2_p_1;
      end
    endcase
  end

  always_comb begin
    w_lane      = dmem_rdata >> {r_ld_lo, 3'b000};
    w_load_data = w_lane;
    case (r_ld_f3)
      3'd0:    w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'd1:    w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'd4:    w_load_data = {24'd0, w_lane[7:0]};
      3'd5:    w_load_data = {16'd0, w_lane[15:0]};
      default: w_load_data = w_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_ld_f3    <= '0;
      r_ld_lo    <= '0;
      r_pen      <= 1'b0;
      r_rad      <= '0;
      r_rad_zero <= 1'b0;
      r_rdd      <= '0;
      r_wr_en    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_pen      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_memop_valid) begin
            r_state <= S_BUS;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= {alu_p_1[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_ld_f3 <= w_f3;
            r_ld_lo <= alu_p_1[1:0];
          end else if (pen_p_1) begin
            r_pen      <= 1'b1;
            r_rad      <= rad_p_1;
            r_rad_zero <= rad_zero_p_1;
            if (w_fault) begin
              r_rdd      <= '0;
              r_misalign <= 1'b1;
            end else begin
              r_rdd   <= alu_p_1;
              r_wr_en <= ~rad_zero_p_1 & (w_opcode != OP_BRANCH);
            end
          end
        end
        S_BUS: begin
          // Ack wins over a timeout landing in the same cycle.
          if (dmem_ack) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_pen      <= 1'b1;
            r_rad      <= rad_p_1;
            r_rad_zero <= rad_zero_p_1;
            if (r_we) begin
              r_rdd <= '0;
            end else begin
              r_rdd   <= w_load_data;
              r_wr_en <= ~rad_zero_p_1;
            end
          end else if (w_timeout) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_pen      <= 1'b1;
            r_rad      <= rad_p_1;
            r_rad_zero <= rad_zero_p_1;
            r_rdd      <= '0;
            r_bus_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
  assign pen        = r_pen;
  assign rad        = r_rad;
  assign rad_zero   = r_rad_zero;
  assign rdd        = r_rdd;
  assign wr_en      = r_wr_en;
  assign misalign   = r_misalign;
  assign bus_err    = r_bus_err;

endmodule
